// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 64-bit signed immediate into the 26-bit
// instruction immediate field for the D, I, CBZ and B formats, and flags
// values that do not fit the selected format.
//
// Handshake: a request transfers on a rising CLK edge where InValid and
// InReady are both 1; a result transfers on a rising CLK edge where
// OutValid and OutReady are both 1. Once OutValid rises, Imm26 and RangeErr
// hold until that transfer. InReady falls after an accepted request and
// rises again only after the result has transferred, so at most one request
// is in flight. InValid is ignored while InReady is 0.
module imm_encoder (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        InValid,
   output logic        InReady,
   input  logic [63:0] BusImm,
   input  logic [1:0]  Ctrl,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [25:0] Imm26,
   output logic        RangeErr,
   output logic [7:0]  ErrCount,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [63:0] imm_q;
   logic [1:0]  ctrl_q;
   logic [25:0] field;
   logic        err;

   // Place the truncated field for the captured format. A value is out of
   // range when the bits from the field's sign bit upward are not all equal.
   always_comb begin
      field = '0;
      err   = 1'b0;
      case (ctrl_q)
         2'b00: begin
            field[20:12] = imm_q[8:0];
            err = !((&imm_q[63:8]) || !(|imm_q[63:8]));
         end
         2'b01: begin
            field[21:10] = imm_q[11:0];
            err = !((&imm_q[63:11]) || !(|imm_q[63:11]));
         end
         2'b10: begin
            field[23:5] = imm_q[18:0];
            err = !((&imm_q[63:18]) || !(|imm_q[63:18]));
         end
         default: begin
            field[25:0] = imm_q[25:0];
            err = !((&imm_q[63:25]) || !(|imm_q[63:25]));
         end
      endcase
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      OutValid  = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) state_nxt = CALC;
         end
         CALC: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            OutValid = 1'b1;
            if (OutReady) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) state <= IDLE;
      else          state <= state_nxt;
   end

   // Capture the request when it is accepted in IDLE.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         imm_q  <= '0;
         ctrl_q <= '0;
      end else if (state == IDLE && InValid) begin
         imm_q  <= BusImm;
         ctrl_q <= Ctrl;
      end
   end

   // Load the result registers in CALC; they stay put through HOLD.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         Imm26    <= '0;
         RangeErr <= 1'b0;
      end else if (state == CALC) begin
         Imm26    <= field;
         RangeErr <= err;
      end
   end

   // Count errored results as they leave HOLD, saturating at 255.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         ErrCount <= '0;
      end else if (state == HOLD && OutReady && RangeErr && ErrCount != 8'hFF) begin
         ErrCount <= ErrCount + 8'd1;
      end
   end

   assign dbg_state = state;

endmodule
